// File: rtl/bnn_pkg.sv
// Shared parameters, state encoding and reset banks for the BNN sequencing controller.
package bnn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int NUM_WEIGHTS = 6;
    localparam int THR_W       = 3;
    localparam int SUM_W       = $clog2(NUM_WEIGHTS + 1);
    localparam int IDX_W       = $clog2(NUM_NEURONS);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_T, COMMIT} state_t;

    typedef logic [NUM_NEURONS-1:0][NUM_WEIGHTS-1:0] wbank_t;
    typedef logic [NUM_NEURONS-1:0][THR_W-1:0]       tbank_t;

    // Element 0 is the rightmost word.
    localparam wbank_t DEF_W = {6'b110011, 6'b001100, 6'b000111, 6'b111000};
    localparam tbank_t DEF_T = {NUM_NEURONS{3'd2}};

    // A threshold above NUM_WEIGHTS could never fire, so it saturates there.
    function automatic logic [THR_W-1:0] clamp_thr(input logic [NUM_WEIGHTS-1:0] data);
        logic [THR_W-1:0] thr;
        thr = data[THR_W-1:0];
        if (thr > THR_W'(NUM_WEIGHTS))
            thr = THR_W'(NUM_WEIGHTS);
        clamp_thr = thr;
    endfunction

endpackage

// File: rtl/bnn_neuron_array.sv
// Combinational XNOR-popcount neuron array with per-neuron threshold compare.
module bnn_neuron_array
    import bnn_pkg::*;
(
    input  wbank_t                  weights,
    input  tbank_t                  thresholds,
    input  logic [NUM_WEIGHTS-1:0]  in_data,
    output logic [NUM_NEURONS-1:0]  fire
);

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
        logic [SUM_W-1:0] sum;
        assign sum     = SUM_W'($countones(~(in_data ^ weights[i])));
        assign fire[i] = (sum >= SUM_W'(thresholds[i]));
    end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Configuration sequencer with shadow/active banks plus a one-deep registered
// inference stage on the XNOR-popcount array.
//
// state  | meaning
// IDLE   | no load in progress, cfg_start accepted
// LOAD_W | streaming weight words into the shadow bank
// LOAD_T | streaming thresholds into the shadow bank
// COMMIT | shadow copied to active, inputs stalled for this cycle
module bnn_seq_ctrl
    import bnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic                    cfg_valid,
    input  logic [NUM_WEIGHTS-1:0]  cfg_data,
    output logic                    cfg_ready,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    input  logic                    in_valid,
    input  logic [NUM_WEIGHTS-1:0]  in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [NUM_NEURONS-1:0]  out_data,
    input  logic                    out_ready
);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    wbank_t                  active_w;
    wbank_t                  shadow_w;
    tbank_t                  active_t;
    tbank_t                  shadow_t;
    logic [NUM_NEURONS-1:0]  fire;
    logic                    last_idx;
    logic                    in_fire;

    assign last_idx = (idx == IDX_W'(NUM_NEURONS - 1));
    // Stalling inputs during COMMIT keeps every result tied to exactly one bank.
    assign in_ready = (!out_valid || out_ready) && (state != COMMIT);
    assign in_fire  = in_valid && in_ready;

    bnn_neuron_array u_array (
        .weights    (active_w),
        .thresholds (active_t),
        .in_data    (in_data),
        .fire       (fire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            active_w  <= DEF_W;
            active_t  <= DEF_T;
            shadow_w  <= DEF_W;
            shadow_t  <= DEF_T;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD_W;
                        idx       <= '0;
                        shadow_w  <= active_w;
                        shadow_t  <= active_t;
                        cfg_ready <= 1'b1;
                        cfg_busy  <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (cfg_abort) begin
                        state     <= IDLE;
                        idx       <= '0;
                        cfg_ready <= 1'b0;
                        cfg_busy  <= 1'b0;
                    end else if (cfg_valid) begin
                        shadow_w[idx] <= cfg_data;
                        if (last_idx) begin
                            state <= LOAD_T;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_T: begin
                    if (cfg_abort) begin
                        state     <= IDLE;
                        idx       <= '0;
                        cfg_ready <= 1'b0;
                        cfg_busy  <= 1'b0;
                    end else if (cfg_valid) begin
                        shadow_t[idx] <= clamp_thr(cfg_data);
                        if (last_idx) begin
                            state     <= COMMIT;
                            idx       <= '0;
                            cfg_ready <= 1'b0;
                            cfg_done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    active_w <= shadow_w;
                    active_t <= shadow_t;
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    cfg_ready <= 1'b0;
                    cfg_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= fire;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
